ifu_prefetch: RTL
=================

Name: ifu_prefetch

Overview:
Parametrised instruction-fetch front end and successor to the single-cycle PC/fetch block. It holds the fetch PC, issues aligned bus-width reads over a valid/ready memory request channel and accepts the returned data. Each returned bus word is split into 32-bit instructions and pushed into a DEPTH-entry prefetch queue. Decode pops {inst, pc} pairs through a valid/ready handshake; redirects from execute flush the queue and restart fetch.

Parameters:
XLEN, 64, PC and address width
BUS_W, 64, memory read data width; legal values 32 or 64
DEPTH, 4, prefetch queue entries; power of two, >= BUS_W/32
RESET_PC, 64'h80000000, fetch PC after reset

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
fetch_en  in  1  permits new memory requests; replaces pcEn
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  XLEN  new fetch PC; bits [1:0] are ignored
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  bus-aligned address, {fetch_pc[XLEN-1:log2(BUS_W/8)], 0}
mem_resp_valid  in  1  read data valid, one pulse per accepted request
mem_resp_data  in  BUS_W  read data; lane k = bits [32k+31:32k]
inst_valid  out  1  queue head valid
inst_ready  in  1  decode accepts head
inst  out  32  head instruction
inst_pc  out  XLEN  head PC

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE, fetch_pc=RESET_PC, queue empty.
  - mem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
- At most one request outstanding. LANES=BUS_W/32. free = DEPTH - count.
- FSM states and transitions:
  - IDLE -> REQ when fetch_en=1, free>=LANES and no redirect.
  - REQ: mem_req_valid=1 with a stable address until handshake. Handshake -> WAIT.
  - WAIT: on mem_resp_valid, write lanes fetch_pc[log2(BUS_W/8)-1:2] .. LANES-1 to the queue in ascending order. Entry pc = aligned address + 4*lane.
  - WAIT then sets fetch_pc = aligned address + BUS_W/8 and goes -> IDLE. It goes -> REQ directly in the same cycle if fetch_en=1 and the post-write free>=LANES.
  - DROP: on mem_resp_valid, discard data -> IDLE.
- Redirect (highest priority, takes effect at the clock edge):
  - Queue flushed and fetch_pc=redirect_pc in all states.
  - IDLE stays IDLE.
  - REQ without a handshake in the same cycle: stays REQ. mem_req_addr switches to the new aligned address next cycle, and valid stays high.
  - REQ with a handshake in the same cycle -> DROP.
  - WAIT -> DROP. If mem_resp_valid arrives in that same cycle, the data is discarded and the next state is IDLE.
  - DROP stays DROP.
- A second redirect while in DROP only updates fetch_pc.
- Queue:
  - Circular buffer with wrap-around head/tail pointers and count 0..DEPTH.
  - Simultaneous push and pop are both performed.
  - The free>=LANES reservation guarantees no overflow. A push when full is a design error and must be caught by an assertion.
  - inst_valid = (count != 0). inst and inst_pc are driven from the head entry.
  - When the queue is empty: inst_valid=0, inst=0, inst_pc=0.
- Pop happens when inst_valid && inst_ready. A pop in the same cycle as a redirect still completes for decode; the queue is empty after the edge.
- fetch_en=0 blocks only IDLE->REQ. An outstanding request still completes and is enqueued.
- mem_resp_valid in IDLE or REQ is ignored.

Decomposition:
- Package ifu_pkg:
  - enum fetch_state_t {IDLE, REQ, WAIT, DROP}
  - INST_W=32
  - default RESET_PC
  - struct fq_entry_t {inst[31:0], pc[XLEN-1:0]}
- Sub-module ifu_fetch_queue: DEPTH-entry FIFO with up to LANES pushes per cycle, one pop, flush and count output.
- ifu_prefetch holds the FSM, fetch_pc, address alignment and lane unpacking.

Test Plan:
- Reset then fetch_en=1, memory with 0 wait states returning 64'hBBBBBBBB_AAAAAAAA at 0x80000000 -> mem_req_addr=0x80000000; queue pops AAAAAAAA@0x80000000 then BBBBBBBB@0x80000004; next request at 0x80000008.
- redirect_pc=0x80000104 with BUS_W=64 -> request addr 0x80000100; only upper lane enqueued, inst_pc=0x80000104; next request 0x80000108.
- inst_ready=0 with DEPTH=4 -> exactly two requests, count=4, mem_req_valid stays 0. Raise inst_ready for one pop -> still no request (free=1). Second pop -> request issued.
- Redirect while in WAIT, response arriving 3 cycles later -> response discarded, queue empty. The next request goes to the redirect address only after that response.
- mem_req_ready held 0 for 5 cycles with a redirect on cycle 2 -> mem_req_valid stays high, and the address changes to the redirect target on cycle 3.
- Assert reset mid-WAIT -> outputs clear immediately, without waiting for a clock edge. After release, the first request is at 0x80000000, and a stale mem_resp_valid in IDLE is ignored.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package ifu_pkg;

    localparam int          INST_W       = 32;
    localparam int          XLEN_DEF     = 64;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0]   inst;
        logic [XLEN_DEF-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// Circular prefetch queue: up to LANES in-order pushes per cycle, one pop, synchronous flush.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter int  LANES   = 2,
    parameter type entry_t = fq_entry_t
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [$clog2(LANES+1)-1:0]     push_n,
    input  entry_t                         push_data [LANES],
    input  logic                           pop,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output entry_t                         head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_pop;

    assign do_pop = pop && (count_q != '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_pop) begin
                head_d = PW'((int'(head_q) + 1) % DEPTH);
            end
            tail_d  = PW'((int'(tail_q) + int'(push_n)) % DEPTH);
            count_d = CW'(int'(count_q) - int'(do_pop) + int'(push_n));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; the head is masked whenever the queue is empty.
    always_ff @(posedge clock) begin
        if (!flush) begin
            for (int j = 0; j < LANES; j++) begin
                if (j < int'(push_n)) begin
                    mem_q[PW'((int'(tail_q) + j) % DEPTH)] <= push_data[j];
                end
            end
        end
    end

    assign count = count_q;
    assign head  = (count_q != '0) ? mem_q[head_q] : '0;

    push_fits_a: assert property (@(posedge clock) disable iff (reset)
        (int'(count_q) + int'(push_n) <= DEPTH))
        else $error("fetch queue overflow: count %0d push %0d", count_q, push_n);

endmodule

// File: rtl/ifu_prefetch.sv
// Fetch FSM, PC tracking, bus alignment and lane unpacking feeding the prefetch queue.
// Handshakes: a transfer happens on a cycle where both valid and ready are high at the clock edge.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              BUS_W    = 64,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [BUS_W-1:0]  mem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [XLEN-1:0]   inst_pc,
    output fetch_state_t      dbg_state_o
);

    localparam int LANES = BUS_W / 32;
    localparam int OFF   = $clog2(BUS_W / 8);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int NW    = $clog2(LANES + 1);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
    } entry_t;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] aligned_pc;
    logic [CW-1:0]   count;
    logic [NW-1:0]   push_n;
    entry_t          push_data [LANES];
    entry_t          head;
    logic            pop, req_fire;
    int              start_lane, free_now, free_post;

    assign aligned_pc = {fetch_pc_q[XLEN-1:OFF], {OFF{1'b0}}};
    assign start_lane = int'(32'(fetch_pc_q[OFF-1:0] >> 2));
    assign req_fire   = (state_q == REQ) && mem_req_ready;
    assign pop        = inst_valid && inst_ready;
    assign free_now   = DEPTH - int'(count);
    assign free_post  = DEPTH - (int'(count) - int'(pop) + int'(push_n));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Redirect outranks everything; a response racing a redirect in WAIT is simply dropped.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE: if (!redirect_valid && fetch_en && free_now >= LANES) state_d = REQ;
            REQ:  if (req_fire) state_d = redirect_valid ? DROP : WAIT;
            WAIT: begin
                if (redirect_valid) begin
                    state_d = mem_resp_valid ? IDLE : DROP;
                end else if (mem_resp_valid) begin
                    state_d    = (fetch_en && free_post >= LANES) ? REQ : IDLE;
                    fetch_pc_d = aligned_pc + XLEN'(BUS_W / 8);
                end
            end
            DROP: if (mem_resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
        end
    end

    always_comb begin
        mem_req_valid = 1'b0;
        push_n        = '0;
        dbg_state_o   = state_q;
        case (state_q)
            REQ:  mem_req_valid = 1'b1;
            WAIT: if (mem_resp_valid && !redirect_valid) push_n = NW'(LANES - start_lane);
            default: ;
        endcase
    end

    // Lanes below the entry lane are skipped; the rest are compacted to push slot 0 upward.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            push_data[j] = '0;
            if (start_lane + j < LANES) begin
                push_data[j].inst = mem_resp_data[(start_lane + j) * INST_W +: INST_W];
                push_data[j].pc   = aligned_pc + XLEN'(4 * (start_lane + j));
            end
        end
    end

    ifu_fetch_queue #(
        .DEPTH   (DEPTH),
        .LANES   (LANES),
        .entry_t (entry_t)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push_n    (push_n),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign mem_req_addr = aligned_pc;
    assign inst_valid   = (count != '0);
    assign inst         = head.inst;
    assign inst_pc      = head.pc;

endmodule
